// File: rtl/io_out_queue_pkg.sv
// rtl/io_out_queue_pkg.sv - shared output-interface codes and controller-internal queue defaults
package io_out_queue_pkg;

    // Output-interface widths and command codes
    localparam int OD_N = 8;
    localparam int OC_N = 2;

    typedef enum logic [OC_N-1:0] {
        OC_NON = 2'd0,
        OC_ACK = 2'd1,
        OC_NUM = 2'd2,
        OC_ERR = 2'd3
    } oc_e;

    // Controller-internal output queue defaults
    localparam int IOQ_DEPTH_DEF   = 4;
    localparam int IOQ_RESERVE_DEF = 2;

endpackage

// File: rtl/io_out_fifo_mem.sv
// rtl/io_out_fifo_mem.sv - DEPTH x W register array, one write port, head and tail async reads
module io_out_fifo_mem #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [W-1:0]               wr_word,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [W-1:0]               rd_word,
    input  logic [$clog2(DEPTH)-1:0]   tail_addr,
    output logic [W-1:0]               tail_word
);

    logic [W-1:0] mem [DEPTH];

    // Storage contents are don't-care until written, so the array has no reset
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign rd_word   = mem[rd_addr];
    assign tail_word = mem[tail_addr];

endmodule

// File: rtl/io_out_queue.sv
// rtl/io_out_queue.sv - registered output event FIFO with in_ack throttling; optional IO_ACK_MERGE_EN
module io_out_queue
    import io_out_queue_pkg::*;
#(
    parameter int OD_W    = OD_N,
    parameter int OC_W    = OC_N,
    parameter int DEPTH   = IOQ_DEPTH_DEF,
    parameter int RESERVE = IOQ_RESERVE_DEF
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     in_en,
    output logic                     in_ack,
    input  logic                     push_valid,
    input  logic [OC_W-1:0]          push_cmd,
    input  logic [OD_W-1:0]          push_data,
    output logic                     push_ready,
    output logic                     out_valid,
    output logic [OC_W-1:0]          out_cmd,
    output logic [OD_W-1:0]          out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = OC_W + OD_W;

    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]     RES_C   = (AW+1)'(RESERVE);
    localparam logic [AW:0]     ONE_C   = (AW+1)'(1);
    localparam logic [OC_W-1:0] CMD_NON = OC_W'(OC_NON);
    localparam logic [OC_W-1:0] CMD_ACK = OC_W'(OC_ACK);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] tail_ptr;
    logic [AW:0]   count;
    logic          ovf_q;
    logic [EW-1:0] head_word;
    logic [EW-1:0] tail_word;

    logic full;
    logic empty;
    logic pop;
    logic push_real;
    logic merge;
    logic wr_en;
    logic ovf_set;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign pop       = !empty && out_ready;
    assign push_real = push_valid && (push_cmd != CMD_NON);
    assign tail_ptr  = wr_ptr - 1'b1;

`ifdef IO_ACK_MERGE_EN
    logic tail_is_ack;
    logic tail_popping;
    logic unused_tail_data;

    // The tail is being popped only when it is also the head (single entry)
    assign tail_is_ack      = (tail_word[EW-1 -: OC_W] == CMD_ACK);
    assign tail_popping     = pop && (count == ONE_C);
    assign merge            = push_real && (push_cmd == CMD_ACK) && !empty
                              && tail_is_ack && !tail_popping;
    assign unused_tail_data = ^tail_word[OD_W-1:0];
`else
    logic unused_tail;
    logic unused_one;

    assign merge       = 1'b0;
    assign unused_tail = ^tail_word;
    assign unused_one  = ^ONE_C;
`endif

    // A merged ACK never takes a slot, so it is safe even while full
    assign wr_en   = push_real && !full && !merge;
    assign ovf_set = push_real && full && !merge;

    io_out_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .Clock     (Clock),
        .wr_en     (wr_en),
        .wr_addr   (wr_ptr),
        .wr_word   ({push_cmd, push_data}),
        .rd_addr   (rd_ptr),
        .rd_word   (head_word),
        .tail_addr (tail_ptr),
        .tail_word (tail_word)
    );

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a same-cycle set beats the clear
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign push_ready = !full;
    assign out_valid  = !empty;
    assign out_cmd    = empty ? CMD_NON : head_word[EW-1 -: OC_W];
    assign out_data   = empty ? '0 : head_word[OD_W-1:0];
    assign level      = count;
    assign overflow   = ovf_q;

    // Only accept new input when the responses it may generate are guaranteed room
    assign in_ack = Reset && in_en && ((DEPTH_C - count) >= RES_C);

endmodule

// File: tb/tb_io_out_queue.sv
// tb/tb_io_out_queue.sv - table vectors plus scoreboard bench for io_out_queue
module tb_io_out_queue;
    import io_out_queue_pkg::*;

    localparam int DEPTH   = 4;
    localparam int RESERVE = 2;

    logic       Clock;
    logic       Reset;
    logic       in_en;
    logic       in_ack;
    logic       push_valid;
    logic [1:0] push_cmd;
    logic [7:0] push_data;
    logic       push_ready;
    logic       out_valid;
    logic [1:0] out_cmd;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       overflow;
    logic       ovf_clr;

    io_out_queue #(
        .OD_W    (8),
        .OC_W    (2),
        .DEPTH   (DEPTH),
        .RESERVE (RESERVE)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .in_en      (in_en),
        .in_ack     (in_ack),
        .push_valid (push_valid),
        .push_cmd   (push_cmd),
        .push_data  (push_data),
        .push_ready (push_ready),
        .out_valid  (out_valid),
        .out_cmd    (out_cmd),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic       pv;
        logic [1:0] cmd;
        logic [7:0] data;
        logic       ordy;
        logic       clr;
        int         exp_level;
        logic       exp_ready;
        logic       exp_ovf;
        logic       exp_ack;
    } vec_t;

    ev_t  sb[$];
    logic m_ovf;
    int   checks;
    int   errors;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check head on pop, advance model, check state after edge
    task automatic step(input logic pv, input logic [1:0] pc, input logic [7:0] pd,
                        input logic ordy, input logic clr);
        logic pop_m, merge_m, full_m, wr_m, set_m, real_m;
        ev_t  e;
        push_valid = pv;
        push_cmd   = pc;
        push_data  = pd;
        out_ready  = ordy;
        ovf_clr    = clr;
        #1;
        pop_m = ordy && (sb.size() != 0);
        if (pop_m) begin
            chk("head_valid", int'(out_valid), 1);
            chk("head_cmd", int'(out_cmd), int'(sb[0].cmd));
            chk("head_data", int'(out_data), int'(sb[0].data));
        end
        real_m  = pv && (pc != OC_NON);
        merge_m = 1'b0;
`ifdef IO_ACK_MERGE_EN
        merge_m = real_m && (pc == OC_ACK) && (sb.size() != 0)
                  && (sb[$].cmd == OC_ACK) && !(pop_m && sb.size() == 1);
`endif
        full_m = (sb.size() == DEPTH);
        wr_m   = real_m && !full_m && !merge_m;
        set_m  = real_m && full_m && !merge_m;
        @(posedge Clock);
        #1;
        if (pop_m) void'(sb.pop_front());
        if (wr_m) begin
            e.cmd  = pc;
            e.data = pd;
            sb.push_back(e);
        end
        m_ovf = set_m ? 1'b1 : (clr ? 1'b0 : m_ovf);
        chk("level", int'(level), sb.size());
        chk("push_ready", int'(push_ready), int'(sb.size() != DEPTH));
        chk("out_valid", int'(out_valid), int'(sb.size() != 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("in_ack", int'(in_ack), int'(in_en && (DEPTH - sb.size() >= RESERVE)));
        if (sb.size() == 0) begin
            chk("empty_cmd", int'(out_cmd), int'(OC_NON));
            chk("empty_data", int'(out_data), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, OC_NON, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_cmd"}, int'(out_cmd), int'(OC_NON));
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_push_ready"}, int'(push_ready), 1);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_in_ack"}, int'(in_ack), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;

        // Fill / overflow / in_ack throttle vectors (in_en=1, DEPTH=4, RESERVE=2)
        tbl[0]  = '{1'b1, OC_NUM, 8'd1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, OC_NUM, 8'd2, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, OC_NUM, 8'd3, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, OC_NUM, 8'd4, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, OC_NUM, 8'd5, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, OC_NON, 8'd0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, OC_NON, 8'd0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, OC_NON, 8'd0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, OC_NON, 8'd0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, OC_NON, 8'd0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, OC_NON, 8'd0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, OC_NON, 8'd9, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};

        Reset      = 1'b0;
        in_en      = 1'b1;
        push_valid = 1'b0;
        push_cmd   = OC_NON;
        push_data  = 8'h00;
        out_ready  = 1'b0;
        ovf_clr    = 1'b0;
        #2;
        check_reset_outputs("rst");
        #5;
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        // Basic pass-through with out_ready held high
        step(1'b1, OC_NUM, 8'h12, 1'b1, 1'b0);
        chk("t1_cmd0", int'(out_cmd), int'(OC_NUM));
        chk("t1_data0", int'(out_data), 'h12);
        step(1'b1, OC_ERR, 8'h00, 1'b1, 1'b0);
        chk("t1_cmd1", int'(out_cmd), int'(OC_ERR));
        chk("t1_valid1", int'(out_valid), 1);
        step(1'b0, OC_NON, 8'h00, 1'b1, 1'b0);
        chk("t1_cmd2", int'(out_cmd), int'(OC_NON));
        chk("t1_valid2", int'(out_valid), 0);

        // Table-driven fill, overflow, drain, clear
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].pv, tbl[i].cmd, tbl[i].data, tbl[i].ordy, tbl[i].clr);
            chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_level);
            chk($sformatf("tbl%0d_ready", i), int'(push_ready), int'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_in_ack", i), int'(in_ack), int'(tbl[i].exp_ack));
        end

        // Overflow set and clear in the same cycle: set wins
        for (int i = 0; i < DEPTH; i++) step(1'b1, OC_NUM, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, OC_ERR, 8'h77, 1'b0, 1'b1);
        chk("setwins_ovf", int'(overflow), 1);
        step(1'b0, OC_NON, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow), 0);
        idle(DEPTH + 1);

        // Steady-state push+pop at level 3 over 10 cycles; pointers wrap
        for (int i = 0; i < 3; i++) step(1'b1, OC_NUM, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, OC_NUM, 8'(8'h43 + i), 1'b1, 1'b0);
            chk("wrap_level", int'(level), 3);
        end
        idle(4);

        // ACK merge behaviour (level 3 with merge, 4 without)
        step(1'b1, OC_ACK, 8'h00, 1'b0, 1'b0);
        step(1'b1, OC_ACK, 8'h00, 1'b0, 1'b0);
        step(1'b1, OC_NUM, 8'h07, 1'b0, 1'b0);
        step(1'b1, OC_ACK, 8'h00, 1'b0, 1'b0);
`ifdef IO_ACK_MERGE_EN
        chk("merge_level", int'(level), 3);
`else
        chk("merge_level", int'(level), 4);
`endif
        idle(5);

        // Asynchronous reset mid-queue
        for (int i = 0; i < 3; i++) step(1'b1, OC_ERR, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("pre_rst_level", int'(level), 3);
        push_valid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outputs("async");
        sb.delete();
        m_ovf = 1'b0;
        #3;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("post_rst_level", int'(level), 0);
        step(1'b1, OC_NUM, 8'h99, 1'b0, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
